joy_split_scan: RTL and testbench

Time-multiplexed joystick scanner for the two-player joystick splitter on the single 6-bit DB9 connector. Drives the splitter select line, waits for the mux and cable to settle, synchronizes and samples the shared pins, debounces each bit, and presents stable per-player buses. Sits directly upstream of the arcade core's `I_JOYSTICK_A` / `I_JOYSTICK_B` inputs and replaces the free-running per-cycle select toggle.

---
 rtl/joy_split_pkg.sv | 15 +
 rtl/joy_debounce.sv | 70 +++++++
 rtl/joy_split_scan.sv | 101 ++++++++++
 tb/tb_joy_split_scan.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/joy_split_pkg.sv
// Shared types and constants for the two-player joystick splitter scanner.
package joy_split_pkg;

  typedef enum logic [1:0] {
    S1Settle,
    S1Sample,
    S2Settle,
    S2Sample
  } joy_state_e;

  localparam int unsigned JOY_W = 6;
  localparam logic [JOY_W-1:0] JOY_RELEASED = 6'h3F;
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/joy_debounce.sv
// Per-bit debouncer for one joystick port. Define JOY_SPLIT_DEBOUNCE_EN to enable
// counting; otherwise each strobed sample is written straight into the output.
module joy_debounce
  import joy_split_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic             CLK,
  input  logic             I_RESET_N,
  input  logic             I_SAMPLE_EN,
  input  logic [JOY_W-1:0] I_SAMPLE,
  output logic [JOY_W-1:0] O_Q
);

  logic [JOY_W-1:0] q_d, q_q;

`ifdef JOY_SPLIT_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_SAMPLES - 1);

  logic [CNT_W-1:0] cnt_d [JOY_W];
  logic [CNT_W-1:0] cnt_q [JOY_W];

  // A differing sample that finds the count already at CntMax is the final one needed.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < JOY_W; i++) begin
      cnt_d[i] = cnt_q[i];
      if (I_SAMPLE_EN) begin
        if (I_SAMPLE[i] == q_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          q_d[i]   = I_SAMPLE[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!I_RESET_N) begin
      q_q <= JOY_RELEASED;
      for (int i = 0; i < JOY_W; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      q_q <= q_d;
      for (int i = 0; i < JOY_W; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  always_comb begin
    q_d = I_SAMPLE_EN ? I_SAMPLE : q_q;
  end

  always_ff @(posedge CLK) begin
    if (!I_RESET_N) begin
      q_q <= JOY_RELEASED;
    end else begin
      q_q <= q_d;
    end
  end
`endif

  assign O_Q = q_q;

endmodule

// File: rtl/joy_split_scan.sv
// Time-multiplexed two-player joystick scanner: drives the splitter select, settles,
// samples the synchronized pins and debounces per port (see JOY_SPLIT_DEBOUNCE_EN).
module joy_split_scan
  import joy_split_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES    = 64,
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic             CLK,
  input  logic             I_RESET_N,
  input  logic [JOY_W-1:0] I_JOY_RAW,
  output logic             O_JOY_SEL,
  output logic [JOY_W-1:0] O_JOY1,
  output logic [JOY_W-1:0] O_JOY2,
  output logic             O_SCAN_TICK
);

  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES);
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_CYCLES - 1);

  logic [JOY_W-1:0] sync1_q, joy_sync_q;
  joy_state_e state_d, state_q;
  logic [SettleW-1:0] settle_d, settle_q;
  logic sel_d, sel_q;
  logic tick_d, tick_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    sel_d    = sel_q;
    tick_d   = 1'b0;
    case (state_q)
      S1Settle: begin
        if (settle_q == '0) state_d = S1Sample;
        else                settle_d = settle_q - SettleW'(1);
      end
      S1Sample: begin
        state_d  = S2Settle;
        settle_d = SettleLoad;
        sel_d    = 1'b1;
      end
      S2Settle: begin
        if (settle_q == '0) state_d = S2Sample;
        else                settle_d = settle_q - SettleW'(1);
      end
      S2Sample: begin
        state_d  = S1Settle;
        settle_d = SettleLoad;
        sel_d    = 1'b0;
        tick_d   = 1'b1;
      end
      default: begin
        state_d  = S1Settle;
        settle_d = SettleLoad;
        sel_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!I_RESET_N) begin
      sync1_q    <= JOY_RELEASED;
      joy_sync_q <= JOY_RELEASED;
      state_q    <= S1Settle;
      settle_q   <= SettleLoad;
      sel_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      sync1_q    <= I_JOY_RAW;
      joy_sync_q <= sync1_q;
      state_q    <= state_d;
      settle_q   <= settle_d;
      sel_q      <= sel_d;
      tick_q     <= tick_d;
    end
  end

  joy_debounce #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) u_port1 (
    .CLK        (CLK),
    .I_RESET_N  (I_RESET_N),
    .I_SAMPLE_EN(state_q == S1Sample),
    .I_SAMPLE   (joy_sync_q),
    .O_Q        (O_JOY1)
  );

  joy_debounce #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) u_port2 (
    .CLK        (CLK),
    .I_RESET_N  (I_RESET_N),
    .I_SAMPLE_EN(state_q == S2Sample),
    .I_SAMPLE   (joy_sync_q),
    .O_Q        (O_JOY2)
  );

  assign O_JOY_SEL   = sel_q;
  assign O_SCAN_TICK = tick_q;

endmodule

// File: tb/tb_joy_split_scan.sv
// Directed bench for joy_split_scan with SETTLE_CYCLES=4, DEBOUNCE_SAMPLES=3.
module tb_joy_split_scan;

  logic       clk;
  logic       rst_n;
  logic [5:0] raw;
  logic       sel;
  logic [5:0] joy1;
  logic [5:0] joy2;
  logic       scan_tick;

  int n_eval = 0;
  int n_fail = 0;

  joy_split_scan #(
    .SETTLE_CYCLES   (4),
    .DEBOUNCE_SAMPLES(3)
  ) dut (
    .CLK        (clk),
    .I_RESET_N  (rst_n),
    .I_JOY_RAW  (raw),
    .O_JOY_SEL  (sel),
    .O_JOY1     (joy1),
    .O_JOY2     (joy2),
    .O_SCAN_TICK(scan_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_eval++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full scan starting right after the edge that enters S1 settle.
  task automatic do_scan(input logic [5:0] p1, input logic [5:0] p2);
    raw = p1;
    repeat (5) step();
    check("scan_sel_p2", {5'd0, sel}, 6'd1);
    check("scan_tick_mid", {5'd0, scan_tick}, 6'd0);
    raw = p2;
    repeat (5) step();
    check("scan_sel_p1", {5'd0, sel}, 6'd0);
    check("scan_tick_end", {5'd0, scan_tick}, 6'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    raw   = 6'h3F;

    // Reset and scan period
    repeat (3) step();
    check("rst_joy1", joy1, 6'h3F);
    check("rst_joy2", joy2, 6'h3F);
    check("rst_sel", {5'd0, sel}, 6'd0);
    check("rst_tick", {5'd0, scan_tick}, 6'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check("period_sel", {5'd0, sel}, {5'd0, ((k % 10) >= 5)});
      check("period_tick", {5'd0, scan_tick}, {5'd0, ((k % 10) == 0)});
    end
    check("period_joy1", joy1, 6'h3F);

`ifdef JOY_SPLIT_DEBOUNCE_EN
    // Port routing: three scans needed
    do_scan(6'h3E, 6'h1F);
    do_scan(6'h3E, 6'h1F);
    check("route_joy1_2scans", joy1, 6'h3F);
    check("route_joy2_2scans", joy2, 6'h3F);
    do_scan(6'h3E, 6'h1F);
    check("route_joy1", joy1, 6'h3E);
    check("route_joy2", joy2, 6'h1F);
    repeat (3) do_scan(6'h3F, 6'h3F);
    check("restore_joy1", joy1, 6'h3F);
    check("restore_joy2", joy2, 6'h3F);

    // Debounce threshold: two samples then release is ignored
    do_scan(6'h3B, 6'h3F);
    do_scan(6'h3B, 6'h3F);
    check("thr2_joy1", joy1, 6'h3F);
    do_scan(6'h3F, 6'h3F);
    check("thr2_rel_joy1", joy1, 6'h3F);
    do_scan(6'h3B, 6'h3F);
    do_scan(6'h3B, 6'h3F);
    check("thr3_pre", joy1, 6'h3F);
    raw = 6'h3B;
    repeat (4) step();
    check("thr3_at_sample", joy1, 6'h3F);
    step();
    check("thr3_after_sample", joy1, 6'h3B);
    check("thr3_joy2", joy2, 6'h3F);
    raw = 6'h3F;
    repeat (5) step();
    repeat (3) do_scan(6'h3F, 6'h3F);
    check("thr_restore", joy1, 6'h3F);

    // Chatter on port-2 bit 4
    for (int s = 0; s < 20; s++) begin
      do_scan(6'h3F, (s % 2 == 0) ? 6'h2F : 6'h3F);
      check("chatter_joy2", joy2, 6'h3F);
    end
    check("chatter_joy1", joy1, 6'h3F);

    // Reset mid-operation after two of three samples
    do_scan(6'h3B, 6'h3F);
    raw = 6'h3B;
    repeat (7) step();
    check("mid_sel_before", {5'd0, sel}, 6'd1);
    check("mid_joy1_before", joy1, 6'h3F);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_sel", {5'd0, sel}, 6'd0);
    check("mid_rst_joy1", joy1, 6'h3F);
    check("mid_rst_tick", {5'd0, scan_tick}, 6'd0);
    do_scan(6'h3B, 6'h3F);
    do_scan(6'h3B, 6'h3F);
    check("mid_post2", joy1, 6'h3F);
    raw = 6'h3B;
    repeat (4) step();
    check("mid_post3_pre", joy1, 6'h3F);
    step();
    check("mid_post3", joy1, 6'h3B);
`else
    // Port routing: one sample sets each output
    do_scan(6'h3E, 6'h1F);
    check("route_joy1", joy1, 6'h3E);
    check("route_joy2", joy2, 6'h1F);
    do_scan(6'h3E, 6'h1F);
    do_scan(6'h3E, 6'h1F);
    check("route_joy1_3", joy1, 6'h3E);
    check("route_joy2_3", joy2, 6'h1F);
    do_scan(6'h3F, 6'h3F);
    check("restore_joy1", joy1, 6'h3F);
    check("restore_joy2", joy2, 6'h3F);

    // One-scan press with no debounce
    raw = 6'h3D;
    repeat (4) step();
    check("press_at_sample", joy1, 6'h3F);
    step();
    check("press_after_sample", joy1, 6'h3D);
    check("press_joy2", joy2, 6'h3F);
    raw = 6'h3F;
    repeat (5) step();
    check("press_hold", joy1, 6'h3D);
    raw = 6'h3F;
    repeat (4) step();
    check("rel_at_sample", joy1, 6'h3D);
    step();
    check("rel_after_sample", joy1, 6'h3F);
    raw = 6'h3F;
    repeat (5) step();

    // Port 2 follows every sample
    do_scan(6'h3F, 6'h2F);
    check("follow_joy2_a", joy2, 6'h2F);
    do_scan(6'h3F, 6'h3F);
    check("follow_joy2_b", joy2, 6'h3F);

    // Reset mid-operation
    do_scan(6'h3D, 6'h1F);
    raw = 6'h3D;
    repeat (7) step();
    check("mid_sel_before", {5'd0, sel}, 6'd1);
    check("mid_joy1_before", joy1, 6'h3D);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_sel", {5'd0, sel}, 6'd0);
    check("mid_rst_joy1", joy1, 6'h3F);
    check("mid_rst_joy2", joy2, 6'h3F);
    do_scan(6'h3D, 6'h3F);
    check("mid_post", joy1, 6'h3D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
